x_timer_ctrl_8_bit: RTL and testbench

Controller that sequences an 8-bit up-counter datapath as a programmable period timer. It supports start/stop/hold control, one-shot and periodic modes, a terminal-count tick and a done flag. It sits between board-level control inputs and the count nets, and drives the per-bit count outputs directly so each bit maps to one PCB net.

---
 rtl/x_timer_ctrl_8_bit.sv | 136 +++++++++++++
 tb/tb_x_timer_ctrl_8_bit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/x_timer_ctrl_8_bit.sv
// x_timer_ctrl_8_bit: programmable 8-bit period timer controller.
// Sequences an up-counter through IDLE/RUN/DONE with one-shot and periodic
// modes, a hold input, a terminal-count tick and a done flag.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start, i_stop        start request, stop request (stop wins)
//   i_hold                 freezes the count while in RUN
//   i_mode                 0 = one-shot, 1 = periodic (latched on start)
//   i_period_7..0          period P, MSB first; 0 means 256 (latched on start)
//   o_count_7..0           current count, one net per bit, MSB first
//   o_busy, o_done         high in RUN / DONE
//   o_tick                 one-cycle registered pulse on terminal count
//
// Build option: define X_TIMER_CTRL_RETRIGGER_EN to let i_start in RUN
// relatch period/mode and restart the count; otherwise it is ignored.
module x_timer_ctrl_8_bit (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_stop,
  input  logic i_hold,
  input  logic i_mode,
  input  logic i_period_7,
  input  logic i_period_6,
  input  logic i_period_5,
  input  logic i_period_4,
  input  logic i_period_3,
  input  logic i_period_2,
  input  logic i_period_1,
  input  logic i_period_0,
  output logic o_count_7,
  output logic o_count_6,
  output logic o_count_5,
  output logic o_count_4,
  output logic o_count_3,
  output logic o_count_2,
  output logic o_count_1,
  output logic o_count_0,
  output logic o_busy,
  output logic o_done,
  output logic o_tick
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mode_q,   mode_d;
  logic             tick_q,   tick_d;

  logic [CNT_W-1:0] period_in;
  logic [CNT_W-1:0] term;
  logic             restart_ok;

  assign period_in = {i_period_7, i_period_6, i_period_5, i_period_4,
                      i_period_3, i_period_2, i_period_1, i_period_0};

  // Modulo-256 subtraction makes P = 0 terminate at 255 (256 counts).
  assign term = period_q - CNT_W'(1);

`ifdef X_TIMER_CTRL_RETRIGGER_EN
  assign restart_ok = 1'b1;
`else
  assign restart_ok = (state_q != ST_RUN);
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;

    if (i_stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (i_start && restart_ok) begin
      // Accepted start from IDLE, DONE, or RUN when retrigger is enabled.
      state_d  = ST_RUN;
      count_d  = '0;
      period_d = period_in;
      mode_d   = i_mode;
    end else begin
      case (state_q)
        ST_IDLE: count_d = '0;
        ST_RUN: begin
          if (!i_hold) begin
            if (count_q == term) begin
              tick_d = 1'b1;
              if (mode_q) count_d = '0;
              else        state_d = ST_DONE;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: ;
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
    end
  end

  assign {o_count_7, o_count_6, o_count_5, o_count_4,
          o_count_3, o_count_2, o_count_1, o_count_0} = count_q;
  assign o_busy = (state_q == ST_RUN);
  assign o_done = (state_q == ST_DONE);
  assign o_tick = tick_q;

endmodule

// File: tb/tb_x_timer_ctrl_8_bit.sv
// Testbench for x_timer_ctrl_8_bit: vector table, directed corner sequences
// and randomized traffic against a behavioural reference model.
module tb_x_timer_ctrl_8_bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r_rst, r_start, r_stop, r_hold, r_mode;
  logic [7:0] r_per;
  logic       c7, c6, c5, c4, c3, c2, c1, c0;
  logic       busy, done, tick;
  logic [7:0] dut_cnt;

  assign dut_cnt = {c7, c6, c5, c4, c3, c2, c1, c0};

  x_timer_ctrl_8_bit dut (
    .i_clk(clk), .i_rst(r_rst), .i_start(r_start), .i_stop(r_stop),
    .i_hold(r_hold), .i_mode(r_mode),
    .i_period_7(r_per[7]), .i_period_6(r_per[6]), .i_period_5(r_per[5]),
    .i_period_4(r_per[4]), .i_period_3(r_per[3]), .i_period_2(r_per[2]),
    .i_period_1(r_per[1]), .i_period_0(r_per[0]),
    .o_count_7(c7), .o_count_6(c6), .o_count_5(c5), .o_count_4(c4),
    .o_count_3(c3), .o_count_2(c2), .o_count_1(c1), .o_count_0(c0),
    .o_busy(busy), .o_done(done), .o_tick(tick)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 idle, 1 run, 2 done; period kept as 1..256.
  int m_state, m_cnt, m_per, m_mode, m_tick;

  function automatic bit start_accepted();
`ifdef X_TIMER_CTRL_RETRIGGER_EN
    return 1'b1;
`else
    return m_state != 1;
`endif
  endfunction

  task automatic model_edge();
    m_tick = 0;
    if (r_rst) begin
      m_state = 0; m_cnt = 0; m_per = 256; m_mode = 0;
    end else if (r_stop) begin
      m_state = 0; m_cnt = 0;
    end else if (r_start && start_accepted()) begin
      m_per   = (r_per == 8'd0) ? 256 : int'(r_per);
      m_mode  = int'(r_mode);
      m_cnt   = 0;
      m_state = 1;
    end else if (m_state == 1 && !r_hold) begin
      if (m_cnt == m_per - 1) begin
        m_tick = 1;
        if (m_mode == 1) m_cnt = 0;
        else m_state = 2;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int dut_vec();
    return int'({dut_cnt, busy, done, tick});
  endfunction

  function automatic int model_vec();
    return int'({8'(m_cnt), m_state == 1, m_state == 2, m_tick == 1});
  endfunction

  // One clock edge: model follows the same sampled inputs, outputs read 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic rst, input logic start, input logic stop,
                        input logic hold, input logic mode, input logic [7:0] per);
    r_rst = rst; r_start = start; r_stop = stop; r_hold = hold;
    r_mode = mode; r_per = per;
  endtask

  typedef struct packed {
    logic       rst, start, stop, hold, mode;
    logic [7:0] per;
    logic [7:0] cnt;
    logic       busy, done, tick;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int tick_at[$];
    int t0;
    logic [7:0] prev;
    bit saw_wrap;

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // One-shot P = 5 plus stop, from reset.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 8'd1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].hold,
             vecs[i].mode, vecs[i].per);
      step();
      check($sformatf("vec%0d", i), dut_vec(),
            int'({vecs[i].cnt, vecs[i].busy, vecs[i].done, vecs[i].tick}));
    end

    // Reset mid-RUN at count 37, held two cycles.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd100); step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 37; i++) step();
    check("pre_reset_cnt37", dut_vec(), int'({8'd37, 1'b1, 1'b0, 1'b0}));
    r_rst = 1'b1;
    step(); check("reset_edge1", dut_vec(), 0);
    step(); check("reset_edge2", dut_vec(), 0);
    r_rst = 1'b0;
    step(); check("after_reset_idle", dut_vec(), 0);

    // Periodic P = 0: 256-cycle tick spacing and 255->0 wrap.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0); step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd77);
    saw_wrap = 1'b0;
    prev = dut_cnt;
    for (int i = 1; i <= 600; i++) begin
      step();
      if (tick) tick_at.push_back(i);
      if (prev == 8'd255 && dut_cnt == 8'd0) saw_wrap = 1'b1;
      prev = dut_cnt;
      if (dut_vec() != model_vec()) check($sformatf("p256_cyc%0d", i), dut_vec(), model_vec());
    end
    check("p256_wrap_seen", int'(saw_wrap), 1);
    check("p256_tick_count", tick_at.size(), 2);
    if (tick_at.size() >= 2) begin
      check("p256_first_tick", tick_at[0], 256);
      check("p256_tick_gap", tick_at[1] - tick_at[0], 256);
    end

    // Periodic P = 1: tick every cycle after the first.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); step();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1); step();
    check("p1_start", dut_vec(), int'({8'd0, 1'b1, 1'b0, 1'b0}));
    r_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("p1_tick%0d", i), dut_vec(), int'({8'd0, 1'b1, 1'b0, 1'b1}));
    end

    // Hold: periodic P = 4, hold 3 cycles at count 2; tick at +7 not +4.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); step();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4); step();
    r_start = 1'b0;
    step(); step();
    check("hold_at2", int'(dut_cnt), 2);
    r_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_cyc%0d", i), dut_vec(), int'({8'd2, 1'b1, 1'b0, 1'b0}));
    end
    r_hold = 1'b0;
    t0 = -1;
    for (int i = 6; i <= 12; i++) begin
      step();
      if (tick && t0 < 0) t0 = i;
    end
    check("hold_tick_offset", t0, 7);

    // Stop + start at terminal count: stop wins, no tick.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); step();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5); step();
    r_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("stop_pre_term", int'(dut_cnt), 4);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5); step();
    check("stop_start_term", dut_vec(), 0);

    // Start in DONE restarts at 0.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3); step();
    r_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("oneshot3_done", dut_vec(), int'({8'd2, 1'b0, 1'b1, 1'b0}));
    r_start = 1'b1; step();
    check("done_restart", dut_vec(), int'({8'd0, 1'b1, 1'b0, 1'b0}));

    // Retrigger at count 10 with P = 20.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0); step();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd20); step();
    r_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("retrig_pre", int'(dut_cnt), 10);
    r_start = 1'b1; step();
`ifdef X_TIMER_CTRL_RETRIGGER_EN
    check("retrigger", dut_vec(), int'({8'd0, 1'b1, 1'b0, 1'b0}));
`else
    check("retrigger", dut_vec(), int'({8'd11, 1'b1, 1'b0, 1'b0}));
`endif
    r_start = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r_rst   = ($urandom_range(0, 199) == 0);
      r_stop  = ($urandom_range(0, 59) == 0);
      r_start = ($urandom_range(0, 19) == 0);
      r_hold  = ($urandom_range(0, 3) == 0);
      r_mode  = 1'($urandom_range(0, 1));
      r_per   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      step();
      check($sformatf("rand%0d", i), dut_vec(), model_vec());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
